// File: rtl/calc_pkg.sv
// ============================================================================
// Module   : calc_pkg
// Desc     : Shared encodings for the calculator control core: ALU op codes,
//            display modes, sequencer states and the default result width.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int CALC_RES_W = 14;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] DISP_OPND = 2'b00;
    localparam logic [1:0] DISP_RES  = 2'b01;
    localparam logic [1:0] DISP_ERR  = 2'b10;

    typedef enum logic [2:0] {
        ST_EDIT   = 3'd0,
        ST_START  = 3'd1,
        ST_BUSY   = 3'd2,
        ST_RESULT = 3'd3,
        ST_ERR    = 3'd4
    } calc_state_t;

    // Lowest set bit of the op button vector selects the operation.
    function automatic logic [1:0] op_from_sel(input logic [3:0] sel);
        logic [1:0] code;
        code = OP_DIV;
        if (sel[0])      code = OP_ADD;
        else if (sel[1]) code = OP_SUB;
        else if (sel[2]) code = OP_MUL;
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/calc_digit_bank.sv
// ============================================================================
// Module   : calc_digit_bank
// Desc     : Four wrapping BCD digit counters and the BCD-to-binary conversion
//            of the two two-digit operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_digit_bank
    import calc_pkg::*;
#(
    parameter int DIGIT_MAX = 9
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [3:0]  inc,
    output logic [15:0] digits,
    output logic [6:0]  opnd_a,
    output logic [6:0]  opnd_b
);

    localparam logic [3:0] c_DIGIT_MAX = 4'(DIGIT_MAX);

    logic [3:0][3:0] w_dig;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        logic [3:0] r_digit;

        always_ff @(posedge clk_in or negedge rst_n) begin
            if (!rst_n) begin
                r_digit <= '0;
            end else if (inc[i]) begin
                r_digit <= (r_digit == c_DIGIT_MAX) ? 4'd0 : r_digit + 4'd1;
            end
        end

        assign w_dig[i] = r_digit;
    end

    // Digit 0 (A tens) occupies the most significant nibble of the display word.
    assign digits = {w_dig[0], w_dig[1], w_dig[2], w_dig[3]};
    assign opnd_a = 7'd10 * {3'b000, w_dig[0]} + {3'b000, w_dig[1]};
    assign opnd_b = 7'd10 * {3'b000, w_dig[2]} + {3'b000, w_dig[3]};

endmodule

`default_nettype wire

// File: rtl/calc_op_sequencer.sv
// ============================================================================
// Module   : calc_op_sequencer
// Desc     : Calculator control core: owns the operand digits, launches ALU
//            operations with a start/done handshake, latches results and
//            selects what the display path shows.
// Options  : CALC_TIMEOUT_EN - when defined, a BUSY watchdog of TIMEOUT_CYC
//            cycles forces the error display if the ALU never completes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int RES_W       = CALC_RES_W,
    parameter int TIMEOUT_CYC = 64,
    parameter int DIGIT_MAX   = 9
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic [3:0]       digit_inc,
    input  logic [3:0]       op_sel,
    input  logic             push,
    output logic             alu_start,
    output logic [1:0]       alu_op,
    output logic [6:0]       alu_a,
    output logic [6:0]       alu_b,
    input  logic             alu_done,
    input  logic [RES_W-1:0] alu_result,
    input  logic             alu_neg,
    output logic [1:0]       disp_mode,
    output logic [15:0]      disp_digits,
    output logic [RES_W-1:0] disp_value,
    output logic             disp_neg,
    output logic             busy
);

    calc_state_t r_state;

    logic       w_idle;
    logic       w_op_any;
    logic       w_apply;
    logic [3:0] w_inc;
    logic [1:0] w_op_code;
    logic [6:0] w_opnd_a;
    logic [6:0] w_opnd_b;

`ifdef CALC_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [c_TMO_W-1:0] r_tmo_cnt;
`endif

    // Button events are honoured only outside an outstanding operation;
    // push outranks op_sel, which outranks digit increments.
    assign w_idle    = (r_state == ST_EDIT) || (r_state == ST_RESULT) || (r_state == ST_ERR);
    assign w_op_any  = |op_sel;
    assign w_apply   = w_idle && !push && !w_op_any;
    assign w_inc     = w_apply ? digit_inc : 4'b0000;
    assign w_op_code = op_from_sel(op_sel);

    calc_digit_bank #(
        .DIGIT_MAX (DIGIT_MAX)
    ) u_digit_bank (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .inc    (w_inc),
        .digits (disp_digits),
        .opnd_a (w_opnd_a),
        .opnd_b (w_opnd_b)
    );

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_EDIT;
            alu_start  <= 1'b0;
            alu_op     <= OP_ADD;
            alu_a      <= '0;
            alu_b      <= '0;
            disp_mode  <= DISP_OPND;
            disp_value <= '0;
            disp_neg   <= 1'b0;
            busy       <= 1'b0;
`ifdef CALC_TIMEOUT_EN
            r_tmo_cnt  <= '0;
`endif
        end else begin
            alu_start <= 1'b0;
            case (r_state)
                ST_EDIT, ST_RESULT, ST_ERR: begin
                    if (push) begin
                        r_state   <= ST_EDIT;
                        disp_mode <= DISP_OPND;
                    end else if (w_op_any) begin
                        if ((w_op_code == OP_DIV) && (w_opnd_b == 7'd0)) begin
                            r_state   <= ST_ERR;
                            disp_mode <= DISP_ERR;
                        end else begin
                            r_state   <= ST_START;
                            alu_op    <= w_op_code;
                            alu_a     <= w_opnd_a;
                            alu_b     <= w_opnd_b;
                            alu_start <= 1'b1;
                            busy      <= 1'b1;
                            disp_mode <= DISP_OPND;
                        end
                    end else if (|digit_inc) begin
                        r_state   <= ST_EDIT;
                        disp_mode <= DISP_OPND;
                    end
                end
                ST_START: begin
                    r_state   <= ST_BUSY;
`ifdef CALC_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                ST_BUSY: begin
                    if (alu_done) begin
                        r_state    <= ST_RESULT;
                        disp_value <= alu_result;
                        disp_neg   <= alu_neg;
                        disp_mode  <= DISP_RES;
                        busy       <= 1'b0;
`ifdef CALC_TIMEOUT_EN
                    end else if (r_tmo_cnt == c_TMO_W'(TIMEOUT_CYC - 1)) begin
                        r_state   <= ST_ERR;
                        disp_mode <= DISP_ERR;
                        busy      <= 1'b0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
`endif
                    end
                end
                default: begin
                    r_state <= ST_EDIT;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
// ============================================================================
// Module   : tb_calc_op_sequencer
// Desc     : Directed self-checking bench for calc_op_sequencer with a
//            behavioural reference model compared on every falling edge.
// Options  : CALC_TIMEOUT_EN - exercises the BUSY watchdog when defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_calc_op_sequencer;

    localparam int RES_W = 14;
    localparam int TMO   = 16;

    logic             clk_in;
    logic             rst_n;
    logic [3:0]       digit_inc;
    logic [3:0]       op_sel;
    logic             push;
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [6:0]       alu_a;
    logic [6:0]       alu_b;
    logic             alu_done;
    logic [RES_W-1:0] alu_result;
    logic             alu_neg;
    logic [1:0]       disp_mode;
    logic [15:0]      disp_digits;
    logic [RES_W-1:0] disp_value;
    logic             disp_neg;
    logic             busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the outputs must show after each rising edge.
    int m_d[4];
    int m_mode, m_value, m_neg, m_op, m_a, m_b, m_wait;
    bit m_start, m_busy;

    calc_op_sequencer #(
        .RES_W       (RES_W),
        .TIMEOUT_CYC (TMO),
        .DIGIT_MAX   (9)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .digit_inc   (digit_inc),
        .op_sel      (op_sel),
        .push        (push),
        .alu_start   (alu_start),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_done    (alu_done),
        .alu_result  (alu_result),
        .alu_neg     (alu_neg),
        .disp_mode   (disp_mode),
        .disp_digits (disp_digits),
        .disp_value  (disp_value),
        .disp_neg    (disp_neg),
        .busy        (busy)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_d[i] = 0;
        m_mode = 0; m_value = 0; m_neg = 0; m_op = 0; m_a = 0; m_b = 0; m_wait = 0;
        m_start = 1'b0; m_busy = 1'b0;
    endtask

    task automatic m_update(input logic [3:0] di, input logic [3:0] op, input logic p,
                            input logic dn, input int res, input logic ng);
        int code;
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (m_busy) begin
            if (m_start) begin
                m_start = 1'b0;
                m_wait  = 0;
            end else if (dn) begin
                m_value = res; m_neg = ng; m_mode = 1; m_busy = 1'b0;
            end else begin
`ifdef CALC_TIMEOUT_EN
                m_wait++;
                if (m_wait == TMO) begin
                    m_mode = 2; m_busy = 1'b0;
                end
`endif
            end
        end else if (p) begin
            m_mode = 0;
        end else if (op != 4'b0000) begin
            code = 0;
            for (int i = 3; i >= 0; i--) if (op[i]) code = i;
            if (code == 3 && (10 * m_d[2] + m_d[3]) == 0) begin
                m_mode = 2;
            end else begin
                m_op = code;
                m_a = 10 * m_d[0] + m_d[1];
                m_b = 10 * m_d[2] + m_d[3];
                m_start = 1'b1; m_busy = 1'b1; m_mode = 0;
            end
        end else if (di != 4'b0000) begin
            for (int i = 0; i < 4; i++) if (di[i]) m_d[i] = (m_d[i] + 1) % 10;
            m_mode = 0;
        end
    endtask

    // Drive one cycle of inputs from a falling edge; returns at the next falling edge.
    task automatic cycle(input logic [3:0] di, input logic [3:0] op, input logic p,
                         input logic dn, input int res, input logic ng);
        digit_inc = di; op_sel = op; push = p;
        alu_done = dn; alu_result = RES_W'(res); alu_neg = ng;
        @(posedge clk_in);
        m_update(di, op, p, dn, res, ng);
        @(negedge clk_in);
        digit_inc = '0; op_sel = '0; push = 1'b0; alu_done = 1'b0; alu_result = '0; alu_neg = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(4'h0, 4'h0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    task automatic set_digits(input int t0, input int t1, input int t2, input int t3);
        int need[4];
        logic [3:0] mask;
        need[0] = (t0 - m_d[0] + 10) % 10;
        need[1] = (t1 - m_d[1] + 10) % 10;
        need[2] = (t2 - m_d[2] + 10) % 10;
        need[3] = (t3 - m_d[3] + 10) % 10;
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 4; i++) mask[i] = (need[i] > k);
            if (mask != 4'h0) cycle(mask, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        end
    endtask

    always @(negedge clk_in) begin
        chk("alu_start",   alu_start,   m_start);
        chk("busy",        busy,        m_busy);
        chk("alu_op",      alu_op,      m_op);
        chk("alu_a",       alu_a,       m_a);
        chk("alu_b",       alu_b,       m_b);
        chk("disp_mode",   disp_mode,   m_mode);
        chk("disp_digits", disp_digits, m_d[0] * 4096 + m_d[1] * 256 + m_d[2] * 16 + m_d[3]);
        chk("disp_value",  disp_value,  m_value);
        chk("disp_neg",    disp_neg,    m_neg);
    end

    initial begin
        rst_n = 1'b0;
        digit_inc = '0; op_sel = '0; push = 1'b0;
        alu_done = 1'b0; alu_result = '0; alu_neg = 1'b0;
        m_reset();
        idle(3);
        chk("rst_digits", disp_digits, 0);
        chk("rst_mode", disp_mode, 0);
        rst_n = 1'b1;

        // Wrapping digits
        repeat (10) cycle(4'b0001, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("wrap_d0", disp_digits, 16'h0000);
        repeat (9) cycle(4'b1111, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("all_nine", disp_digits, 16'h9999);

        // Multiply 99*99; a done during START must be ignored
        cycle(4'h0, 4'b0100, 1'b0, 1'b0, 0, 1'b0);
        chk("mul_start", alu_start, 1);
        chk("mul_a", alu_a, 99);
        chk("mul_b", alu_b, 99);
        chk("mul_op", alu_op, 2);
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 1234, 1'b0);
        chk("mul_still_busy", busy, 1);
        idle(2);
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 9801, 1'b0);
        chk("mul_mode", disp_mode, 1);
        chk("mul_value", disp_value, 9801);

        // Subtract with negative result; two op bits, lowest wins
        set_digits(3, 2, 9, 8);
        chk("sub_digits", disp_digits, 16'h3298);
        cycle(4'h0, 4'b1010, 1'b0, 1'b0, 0, 1'b0);
        chk("sub_op", alu_op, 1);
        chk("sub_a", alu_a, 32);
        idle(1);
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 66, 1'b1);
        chk("sub_value", disp_value, 66);
        chk("sub_neg", disp_neg, 1);
        cycle(4'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0);
        chk("push_mode", disp_mode, 0);
        chk("push_digits", disp_digits, 16'h3298);

        // Coincident push + op + digit in EDIT: push wins, others dropped
        cycle(4'hF, 4'b0001, 1'b1, 1'b0, 0, 1'b0);
        chk("prio_digits", disp_digits, 16'h3298);
        chk("prio_start", alu_start, 0);

        // Divide by zero
        set_digits(3, 2, 0, 0);
        cycle(4'h0, 4'b1000, 1'b0, 1'b0, 0, 1'b0);
        chk("div0_mode", disp_mode, 2);
        chk("div0_start", alu_start, 0);
        chk("div0_keep_value", disp_value, 66);
        idle(1);
        cycle(4'b1000, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("err_inc_digits", disp_digits, 16'h3201);
        chk("err_inc_mode", disp_mode, 0);

        // Inputs dropped while busy
        set_digits(3, 2, 1, 0);
        cycle(4'h0, 4'b1000, 1'b0, 1'b0, 0, 1'b0);
        idle(1);
        cycle(4'hF, 4'b0001, 1'b1, 1'b0, 0, 1'b0);
        cycle(4'h0, 4'b0100, 1'b0, 1'b0, 0, 1'b0);
        cycle(4'b0001, 4'h0, 1'b0, 1'b0, 0, 1'b0);
        chk("drop_digits", disp_digits, 16'h3210);
        chk("drop_op", alu_op, 3);
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 3, 1'b0);
        chk("div_value", disp_value, 3);

        // New op straight from RESULT
        cycle(4'h0, 4'b0001, 1'b0, 1'b0, 0, 1'b0);
        chk("add_b", alu_b, 10);
        idle(1);
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 42, 1'b0);
        chk("add_value", disp_value, 42);

        // Withheld completion
        cycle(4'h0, 4'b0001, 1'b0, 1'b0, 0, 1'b0);
        idle(TMO + 2);
`ifdef CALC_TIMEOUT_EN
        chk("tmo_mode", disp_mode, 2);
        chk("tmo_busy", busy, 0);
`else
        chk("wait_busy", busy, 1);
`endif
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 500, 1'b0);
`ifdef CALC_TIMEOUT_EN
        chk("tmo_late_done", disp_value, 42);
`else
        chk("wait_done", disp_value, 500);
`endif

        // Asynchronous reset in the middle of BUSY
        cycle(4'h0, 4'b0001, 1'b0, 1'b0, 0, 1'b0);
        idle(2);
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_a", alu_a, 0);
        chk("arst_value", disp_value, 0);
        chk("arst_digits", disp_digits, 0);
        idle(2);
        #3 rst_n = 1'b1;
        cycle(4'h0, 4'h0, 1'b0, 1'b1, 77, 1'b1);
        chk("stray_done_value", disp_value, 0);
        chk("stray_done_mode", disp_mode, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/calc_op_sequencer.md
Name: calc_op_sequencer

Overview:
Control core of the FPGA calculator. Takes single-cycle button events (digit increments, operation select, push-to-return), owns the four BCD operand digits, and runs a start/done handshake with the multi-cycle arithmetic unit. It latches each result and tells the display path what to show. Sits between the button edge detectors and the ALU plus 7-segment display mux inside main.

Parameters:
RES_W, 14, result magnitude width; covers 99*99 = 9801.
TIMEOUT_CYC, 64, BUSY watchdog limit in clk_in cycles; used only with CALC_TIMEOUT_EN.
DIGIT_MAX, 9, highest digit value before wrap to 0.

Ports:
clk_in  in  1  system clock; all state changes on its rising edge.
rst_n  in  1  asynchronous active-low reset.
digit_inc  in  4  one-cycle pulse per digit; bit0/1 = operand A tens/units, bit2/3 = operand B tens/units.
op_sel  in  4  one-cycle op pulse; bit0 add, bit1 sub, bit2 mul, bit3 div.
push  in  1  one-cycle pulse; return the display to the operands.
alu_start  out  1  one-cycle start strobe to the ALU.
alu_op  out  2  00 add, 01 sub, 10 mul, 11 div.
alu_a  out  7  operand A, binary 0..99.
alu_b  out  7  operand B, binary 0..99.
alu_done  in  1  one-cycle ALU completion strobe.
alu_result  in  RES_W  ALU magnitude; quotient only for div.
alu_neg  in  1  ALU sign; result is negative.
disp_mode  out  2  00 operands, 01 result, 10 error.
disp_digits  out  16  four BCD operand digits; digit0 in [15:12].
disp_value  out  RES_W  latched result magnitude.
disp_neg  out  1  latched result sign.
busy  out  1  high while an operation is outstanding.

Behaviour:
- Reset (async assert, sync release): state EDIT; all digits 0; alu_start 0; alu_op 00; alu_a/alu_b 0; disp_mode 00; disp_value 0; disp_neg 0; busy 0.
- States: EDIT, START, BUSY, RESULT, ERR.
- Digit arithmetic: each set digit_inc bit increments its digit. DIGIT_MAX wraps to 0. Simultaneous bits all apply in the same cycle.
- Operand values: alu_a = 10*d0 + d1 and alu_b = 10*d2 + d3. Both are registered and updated only on entry to START.
- EDIT: digit_inc updates digits. On op_sel != 0, the lowest set bit wins.
  - div with B = 0 goes to ERR with no alu_start.
  - Otherwise go to START and load alu_op, alu_a and alu_b.
- START: alu_start = 1 for exactly this cycle, then go to BUSY. An op pulse in cycle N gives alu_start in cycle N+1.
- BUSY: busy = 1 and alu_op/a/b are held stable.
  - On alu_done: latch alu_result into disp_value and alu_neg into disp_neg, then go to RESULT.
  - disp_mode = 01 in the cycle after done.
  - alu_done is sampled only in BUSY; a done in any other state is ignored.
- BUSY input handling: digit_inc, op_sel and push are all ignored (dropped, not queued).
- RESULT/ERR:
  - push returns to EDIT with disp_mode 00 and digits unchanged.
  - op_sel behaves as in EDIT, so a new op runs on the current digits.
  - digit_inc returns to EDIT and applies the increment in the same cycle.
- Input priority when pulses coincide: push > op_sel > digit_inc. Lower-priority pulses in that cycle are dropped.
- Busy flag: busy = 1 in START and BUSY.
- Error display: disp_value and disp_neg keep their last values in ERR; only disp_mode changes.
- Reset mid-operation forces the reset values immediately. A later stray alu_done is ignored.

Optional Feature:
CALC_TIMEOUT_EN:
- Defined: a counter clears on BUSY entry. If alu_done has not arrived within TIMEOUT_CYC cycles, go to ERR and set disp_mode = 10.
- Not defined: BUSY waits indefinitely and there is no counter logic.

Decomposition:
- calc_pkg holds:
  - op encodings: OP_ADD, OP_SUB, OP_MUL, OP_DIV.
  - state enum.
  - disp_mode encodings: DISP_OPND, DISP_RES, DISP_ERR.
  - RES_W default.
- Sub-module calc_digit_bank: four wrapping BCD counters plus the BCD-to-binary operand conversion.

Test Plan:
- Wrap: 10 pulses on digit_inc[0] -> d0 = 0. 9 pulses on every bit -> disp_digits = 16'h9999.
- Multiply: digits 9999, op_sel[2] -> alu_start one cycle later with a = 99, b = 99, op = 10. ALU done with 9801 -> disp_mode 01, disp_value 9801.
- Subtract negative: digits 3298, op_sel[1], ALU returns 66 with neg = 1 -> disp_value 66, disp_neg 1. Then push -> disp_mode 00, digits 3298.
- Divide by zero: digits 3200, op_sel[3] -> no alu_start, disp_mode 10. Next, digit_inc[3] -> EDIT with digits 3201.
- Busy drop: op during BUSY plus push plus digit_inc -> no second alu_start, digits unchanged. Done with 3 for 32/10 -> disp_value 3.
- Timeout (CALC_TIMEOUT_EN): withhold alu_done -> ERR at TIMEOUT_CYC cycles. Reset asserted mid-BUSY -> all outputs at reset values and a later alu_done is ignored.
